// File: rtl/usb_rx_pkg.sv
// Shared types for the low-speed USB receive path: line symbols, receiver
// states and SYNC pattern constants.
package usb_rx_pkg;

  typedef logic [1:0] d_port_t;  // {D+, D-}

  localparam d_port_t SE0 = 2'b00;
  localparam d_port_t J   = 2'b01;  // low-speed idle: D- high
  localparam d_port_t K   = 2'b10;
  localparam d_port_t SE1 = 2'b11;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} rx_state_t;

  // Decoded SYNC bits still expected after the opening K, LSB first.
  localparam logic [6:0] SYNC_BITS = 7'b1000000;

  localparam logic [2:0] ONES_STUFF = 3'd6;

  function automatic logic is_jk(input d_port_t s);
    return (s == J) || (s == K);
  endfunction

endpackage

// File: rtl/usb_rx_unstuff.sv
// NRZI decoder and bit-stuffing tracker. USB_RX_BITSTUFF_CHECK_EN turns a
// decoded 1 in a stuff slot into stuff_err instead of silently dropping it.
module usb_rx_unstuff
  import usb_rx_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  d_port_t d,
  input  logic    strobe,
  input  logic    ones_load,
  input  logic    data_en,
  output logic    rx_bit,
  output logic    bit_en,
  output logic    stuff_err
);

  d_port_t    prev_q, prev_d;
  logic [2:0] ones_q, ones_d;
  logic       jk_strobe;
  logic       stuffed;

  always_comb begin
    jk_strobe = strobe && is_jk(d);
    rx_bit    = (d == prev_q);
    stuffed   = (ones_q == ONES_STUFF);
    bit_en    = jk_strobe && data_en && !stuffed;
`ifdef USB_RX_BITSTUFF_CHECK_EN
    stuff_err = jk_strobe && data_en && stuffed && rx_bit;
`else
    stuff_err = 1'b0;
`endif
    prev_d = jk_strobe ? d : prev_q;
    ones_d = ones_q;
    if (ones_load) begin
      ones_d = 3'd1;  // the final SYNC bit is a 1 and counts toward stuffing
    end else if (jk_strobe && data_en) begin
      ones_d = (stuffed || !rx_bit) ? 3'd0 : ones_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= J;
      ones_q <= 3'd0;
    end else begin
      prev_q <= prev_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/usb_rx_deserializer.sv
// Low-speed USB receive stage: SYNC detect, byte assembly, EOP and error
// detection. Stuff-violation checking is enabled by USB_RX_BITSTUFF_CHECK_EN.
module usb_rx_deserializer
  import usb_rx_pkg::*;
#(
  parameter int EOP_MIN_BITS  = 2,
  parameter int MAX_PKT_BYTES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  d_port_t    d,
  input  logic       strobe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);

  localparam logic [6:0] MAX_BYTES = 7'(MAX_PKT_BYTES);
  localparam logic [2:0] EOP_MIN   = 3'(EOP_MIN_BITS);

  rx_state_t  state_q, state_d;
  logic [2:0] sync_cnt_q, sync_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] se0_cnt_q, se0_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, active_q, active_d;
  logic       eop_q, eop_d, error_q, error_d;

  logic       rx_bit, bit_en, stuff_err, ones_load;
  logic [7:0] byte_next;

  usb_rx_unstuff u_unstuff (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .strobe    (strobe),
    .ones_load (ones_load),
    .data_en   (state_q == DATA),
    .rx_bit    (rx_bit),
    .bit_en    (bit_en),
    .stuff_err (stuff_err)
  );

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    se0_cnt_d  = se0_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    eop_d      = 1'b0;
    error_d    = 1'b0;
    ones_load  = 1'b0;
    byte_next  = {rx_bit, shift_q[7:1]};

    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (d == K) begin
            state_d    = SYNC;
            sync_cnt_d = 3'd1;
          end
        end
        SYNC: begin
          // Corrupt SYNC is treated as line noise: abort without an error.
          if (!is_jk(d) || rx_bit != SYNC_BITS[sync_cnt_q - 3'd1]) begin
            state_d = ABORT;
          end else if (sync_cnt_q == 3'd7) begin
            state_d    = DATA;
            ones_load  = 1'b1;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 7'd0;
          end else begin
            sync_cnt_d = sync_cnt_q + 3'd1;
          end
        end
        DATA: begin
          if (stuff_err || d == SE1) begin
            error_d = 1'b1;
            state_d = ABORT;
          end else if (bit_en) begin
            shift_d   = byte_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == MAX_BYTES) begin
                error_d = 1'b1;
                state_d = ABORT;
              end else begin
                data_d     = byte_next;
                valid_d    = 1'b1;
                byte_cnt_d = byte_cnt_q + 7'd1;
              end
            end
          end else if (d == SE0) begin
            state_d   = EOP;
            se0_cnt_d = 3'd1;
          end
        end
        EOP: begin
          if (d == SE0) begin
            if (se0_cnt_q != 3'd7) se0_cnt_d = se0_cnt_q + 3'd1;
          end else if (d == J && se0_cnt_q >= EOP_MIN) begin
            eop_d   = 1'b1;
            error_d = (bit_cnt_q != 3'd0);
            state_d = IDLE;
          end else begin
            error_d = 1'b1;
            state_d = ABORT;
          end
        end
        ABORT: begin
          if (d == J) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    active_d = (state_d == DATA) || (state_d == EOP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sync_cnt_q <= 3'd0;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 7'd0;
      se0_cnt_q  <= 3'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      eop_q      <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      se0_cnt_q  <= se0_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      eop_q      <= eop_d;
      error_q    <= error_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_active = active_q;
  assign rx_eop    = eop_q;
  assign rx_error  = error_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Self-checking bench for usb_rx_deserializer: directed packet table, random
// packets against a stuffing/NRZI line model, and hand-written corner cases.
module tb_usb_rx_deserializer;
  import usb_rx_pkg::*;

  localparam int TB_MAX = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       strobe;
  d_port_t    d;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_eop, rx_error;

  always #5 clk = ~clk;

  usb_rx_deserializer #(.EOP_MIN_BITS(2), .MAX_PKT_BYTES(TB_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .strobe    (strobe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_eop    (rx_eop),
    .rx_error  (rx_error)
  );

  typedef struct {
    int          nbytes;
    logic [39:0] data;
    int          pbits;
    logic [7:0]  pval;
    int          se0;
    int          exp_nvalid;
    int          exp_eop;
    int          exp_err;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] tx_bytes[$];
  logic [7:0] got_bytes[$];
  int         got_eop, got_err, ones;
  logic       last_eop, last_err, last_active, active_after_sync, eop_on_j;
  d_port_t    line_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One strobed symbol, then one quiet clock in which every pulse must be gone.
  task automatic send(input d_port_t s);
    d = s;
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    if (rx_valid) got_bytes.push_back(rx_data);
    got_eop += int'(rx_eop);
    got_err += int'(rx_error);
    last_eop = rx_eop;
    last_err = rx_error;
    last_active = rx_active;
    @(posedge clk); #1;
    check("pulse_width", {29'd0, rx_valid, rx_eop, rx_error}, 32'd0);
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it.
  task automatic send_bit(input logic b);
    if (!b) line_cur = (line_cur == J) ? K : J;
    send(line_cur);
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      send_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic start_obs();
    got_bytes.delete();
    got_eop = 0;
    got_err = 0;
    ones = 0;
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_data_bit(1'b0);
    send_data_bit(1'b1);
    active_after_sync = last_active;
  endtask

  task automatic send_eop(input int se0);
    for (int i = 0; i < se0; i++) send(SE0);
    line_cur = J;
    send(J);
    eop_on_j = last_eop;
    send(J);
    send(J);
  endtask

  task automatic run_packet(input int pbits, input logic [7:0] pval, input int se0);
    start_obs();
    send_sync();
    foreach (tx_bytes[i])
      for (int b = 0; b < 8; b++) send_data_bit(tx_bytes[i][b]);
    for (int b = 0; b < pbits; b++) send_data_bit(pval[b]);
    send_eop(se0);
  endtask

  task automatic check_packet(input string tag, input int exp_nvalid, input int exp_eop, input int exp_err);
    check({tag, "_active_after_sync"}, 32'(active_after_sync), 32'd1);
    check({tag, "_nvalid"}, got_bytes.size(), exp_nvalid);
    for (int i = 0; i < exp_nvalid && i < got_bytes.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[i]), 32'(tx_bytes[i]));
    check({tag, "_eop_count"}, got_eop, exp_eop);
    check({tag, "_eop_on_j"}, 32'(eop_on_j), exp_eop);
    check({tag, "_err_count"}, got_err, exp_err);
    check({tag, "_active_end"}, 32'(rx_active), 32'd0);
    if (exp_nvalid > 0)
      check({tag, "_data_held"}, 32'(rx_data), 32'(tx_bytes[exp_nvalid-1]));
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1, 40'h00000000C3, 0, 8'h00, 2, 1, 1, 0};  // basic byte
    vecs[1] = '{2, 40'h000000FFFF, 0, 8'h00, 2, 2, 1, 0};  // stuffing inside data
    vecs[2] = '{0, 40'h0000000000, 0, 8'h00, 2, 0, 1, 0};  // zero-byte packet
    vecs[3] = '{5, 40'h5544332211, 0, 8'h00, 2, 4, 0, 1};  // babble
    vecs[4] = '{1, 40'h0000000000, 3, 8'h05, 2, 1, 1, 1};  // partial byte at EOP
    vecs[5] = '{1, 40'h000000005A, 0, 8'h00, 1, 1, 0, 1};  // EOP too short
    vecs[6] = '{1, 40'h00000000FC, 0, 8'h00, 2, 1, 1, 0};  // stuff bit right before SE0
    vecs[7] = '{3, 40'h0000563412, 0, 8'h00, 3, 3, 1, 0};
    vecs[8] = '{4, 40'h00EFBEADDE, 0, 8'h00, 2, 4, 1, 0};  // exactly the byte limit

    reset = 1'b1;
    strobe = 1'b0;
    d = J;
    line_cur = J;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {23'd0, rx_data, rx_valid, rx_active, rx_eop, rx_error}, 32'd0);
    reset = 1'b0;
    send(J);

    for (int v = 0; v < 9; v++) begin
      tx_bytes.delete();
      for (int i = 0; i < vecs[v].nbytes; i++) tx_bytes.push_back(vecs[v].data[8*i +: 8]);
      run_packet(vecs[v].pbits, vecs[v].pval, vecs[v].se0);
      check_packet($sformatf("vec%0d", v), vecs[v].exp_nvalid, vecs[v].exp_eop, vecs[v].exp_err);
    end

    // Seven consecutive 1s on the line: SYNC's final 1 plus six data 1s.
    start_obs();
    send_sync();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_bit(1'b1);
`ifdef USB_RX_BITSTUFF_CHECK_EN
    check("stuffviol_err_now", 32'(last_err), 32'd1);
    check("stuffviol_active", 32'(last_active), 32'd0);
`else
    check("stuffviol_err_now", 32'(last_err), 32'd0);
    check("stuffviol_active", 32'(last_active), 32'd1);
`endif
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_eop(2);
    tx_bytes.delete();
    tx_bytes.push_back(8'h1F);
`ifdef USB_RX_BITSTUFF_CHECK_EN
    check("stuffviol_nvalid", got_bytes.size(), 0);
    check("stuffviol_eop", got_eop, 0);
    check("stuffviol_err", got_err, 1);
`else
    check_packet("stuffviol", 1, 1, 0);
`endif

    // Corrupt SYNC is silent noise.
    start_obs();
    send(K); send(J); send(K); send(J); send(J); send(J);
    line_cur = J;
    check("badsync_pulses", got_bytes.size() + got_eop + got_err, 0);
    check("badsync_active", 32'(rx_active), 32'd0);

    // Reset in the middle of DATA.
    start_obs();
    send_sync();
    send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1); send_data_bit(1'b1);
    check("middata_active", 32'(rx_active), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_outputs", {23'd0, rx_data, rx_valid, rx_active, rx_eop, rx_error}, 32'd0);
    reset = 1'b0;
    line_cur = J;
    send(J);
    tx_bytes.delete();
    tx_bytes.push_back(8'h96);
    run_packet(0, 8'h00, 2);
    check_packet("after_reset", 1, 1, 0);

    // Random packets against the packet-level model.
    for (int p = 0; p < 40; p++) begin
      int n, pbits, se0, exp_nvalid, exp_eop, exp_err;
      logic [7:0] pval;
      logic babble;
      n = $urandom_range(0, TB_MAX + 1);
      babble = (n > TB_MAX);
      pbits = babble ? 0 : $urandom_range(0, 7);
      pval = 8'($urandom);
      se0 = $urandom_range(1, 3);
      tx_bytes.delete();
      for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
      exp_nvalid = babble ? TB_MAX : n;
      exp_eop = (!babble && se0 >= 2) ? 1 : 0;
      exp_err = (babble || pbits != 0 || se0 < 2) ? 1 : 0;
      run_packet(pbits, pval, se0);
      check_packet($sformatf("rand%0d", p), exp_nvalid, exp_eop, exp_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
